// File: rtl/nibble_serial_add_ctrl.sv
// ============================================================================
//  Module  : nibble_serial_add_ctrl (with helper four_bit_adder)
//  Purpose : WIDTH-bit add computed one nibble per clock through a single
//            4-bit adder, with valid/ready handshakes on both sides.
//            Optional macro NIBBLE_ADD_SUB_EN adds a subtract request port.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module four_bit_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
endmodule

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:4*NIBBLES-1]   a,
    input  logic [0:4*NIBBLES-1]   b,
    input  logic                   carry_in,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:4*NIBBLES-1]   sum,
    output logic                   carry_out,
    output logic                   busy
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] c_LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cy;
    logic              r_co;
    logic [IDXW-1:0]   r_idx;

    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_b_load;
    logic              w_cy_load;
    logic [3:0]        w_nib_sum;
    logic              w_nib_cout;
    logic              w_accept;
    logic              w_last;

    // Ports use ascending ranges with index 0 as LSB; internals are descending.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bitmap
        assign w_a[i] = a[i];
        assign w_b[i] = b[i];
        assign sum[i] = r_sum[i];
    end

`ifdef NIBBLE_ADD_SUB_EN
    assign w_b_load  = sub ? ~w_b : w_b;
    assign w_cy_load = sub | carry_in;
`else
    assign w_b_load  = w_b;
    assign w_cy_load = carry_in;
`endif

    four_bit_adder u_add (
        .i_a    (r_a[{r_idx, 2'b00} +: 4]),
        .i_b    (r_b[{r_idx, 2'b00} +: 4]),
        .i_cin  (r_cy),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_last    = (r_state == S_RUN) && (r_idx == c_LAST);
    assign carry_out = r_co;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_idx == c_LAST) w_state_next = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_cy  <= 1'b0;
            r_co  <= 1'b0;
            r_idx <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= w_a;
                r_b   <= w_b_load;
                r_cy  <= w_cy_load;
                r_idx <= '0;
            end
            if (r_state == S_RUN) begin
                r_sum[{r_idx, 2'b00} +: 4] <= w_nib_sum;
                r_cy  <= w_nib_cout;
                r_idx <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) r_co <= w_nib_cout;
            end
        end
    end
endmodule

`default_nettype wire
